// File: rtl/rf_mp_byp_if.sv
// Read/write port bundle for rf_mp_byp: per-port enables, addresses and data.
// The slave side is the register file; the master side is whoever drives it.
interface rf_mp_byp_if #(
  parameter int W    = 32,
  parameter int N    = 16,
  parameter int RD_N = 2,
  parameter int WR_N = 2,
  localparam int AW  = $clog2(N)
) ();
  logic [RD_N-1:0]         i_ren;
  logic [RD_N-1:0][AW-1:0] i_ra;
  logic [RD_N-1:0][W-1:0]  o_rdata;
  logic [RD_N-1:0]         o_rvalid;
  logic [WR_N-1:0]         i_wen;
  logic [WR_N-1:0][AW-1:0] i_wa;
  logic [WR_N-1:0][W-1:0]  i_wdata;

  modport slave  (input  i_ren, i_ra, i_wen, i_wa, i_wdata,
                  output o_rdata, o_rvalid);
  modport master (output i_ren, i_ra, i_wen, i_wa, i_wdata,
                  input  o_rdata, o_rvalid);
endinterface

// File: rtl/rf_mp_byp.sv
// Multi-port register file with per-word valid bits, registered write-first
// reads and a zeroing sweep after reset or on request.
module rf_mp_byp #(
  parameter int W    = 32,
  parameter int N    = 16,
  parameter int RD_N = 2,
  parameter int WR_N = 2,
  localparam int AW  = $clog2(N)
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          i_init,
  output logic          o_init_done,
  rf_mp_byp_if.slave    bus
);

  typedef enum logic {S_INIT = 1'b0, S_READY = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          cnt_q, cnt_d;
  logic [N-1:0]           valid_q;
  logic [W-1:0]           mem_q [N];
  logic [RD_N-1:0][W-1:0] rdata_q;
  logic [RD_N-1:0]        rvalid_q;
  logic [RD_N-1:0]        fwd_hit;
  logic [RD_N-1:0][W-1:0] fwd_data;

  // Addresses at or above N exist in the address space but hold no word.
  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < (AW+1)'(N);
  endfunction

  // Same-cycle write matching each read address; later ports override earlier.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    fwd_hit  = '0;
    fwd_data = '0;
    for (int r = 0; r < RD_N; r++) begin
      for (int p = 0; p < WR_N; p++) begin
        if (bus.i_wen[p] && bus.i_wa[p] == bus.i_ra[r]) begin
          fwd_hit[r]  = 1'b1;
          fwd_data[r] = bus.i_wdata[p];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT: begin
        if (cnt_q == AW'(N - 1)) begin
          state_d = S_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      S_READY: if (i_init) state_d = S_INIT;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= S_INIT;
      cnt_q    <= '0;
      valid_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments; in the port loop the last
      // assignment to the same bit wins, which gives the highest port priority.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_INIT) begin
        valid_q[cnt_q] <= 1'b0;
        rdata_q        <= '0;
        rvalid_q       <= '0;
      end else begin
        for (int p = 0; p < WR_N; p++) begin
          if (bus.i_wen[p] && in_range(bus.i_wa[p])) valid_q[bus.i_wa[p]] <= 1'b1;
        end
        for (int r = 0; r < RD_N; r++) begin
          if (bus.i_ren[r]) begin
            if (!in_range(bus.i_ra[r])) begin
              rdata_q[r]  <= '0;
              rvalid_q[r] <= 1'b0;
            end else if (fwd_hit[r]) begin
              rdata_q[r]  <= fwd_data[r];
              rvalid_q[r] <= 1'b1;
            end else begin
              rdata_q[r]  <= mem_q[bus.i_ra[r]];
              rvalid_q[r] <= valid_q[bus.i_ra[r]];
            end
          end
        end
      end
    end
  end

  // NOTE: the data array has no reset so it maps onto plain storage; the sweep
  // zeroes it instead, and valid bits hide stale contents meanwhile.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      mem_q[cnt_q] <= '0;
    end else begin
      for (int p = 0; p < WR_N; p++) begin
        if (bus.i_wen[p] && in_range(bus.i_wa[p])) mem_q[bus.i_wa[p]] <= bus.i_wdata[p];
      end
    end
  end

  assign bus.o_rdata  = rdata_q;
  assign bus.o_rvalid = rvalid_q;
  assign o_init_done  = (state_q == S_READY);

endmodule

// File: doc/rf_mp_byp.md
# rf_mp_byp

Parametrised multi-port register file with per-word valid tracking and a built-in initialisation sweep. Writes take effect at the clock edge; reads are registered and use write-first forwarding. Port collisions resolve deterministically. It replaces the flat combinational-read register file wherever pipeline state needs a clean, known-zero start and a 1-cycle registered read that timing closes.

## Interface
- W, 32: word width (bits), >= 1
- N, 16: word count, >= 2; need not be a power of two
- RD_N, 2: read port count, >= 1
- WR_N, 2: write port count, >= 1
- AW, $clog2(N): address width (derived, not overridden)
- clk  in  1  clock; all state on rising edge
- arst_n  in  1  reset, asynchronous assert, active-low
- i_init  in  1  soft re-initialisation request, sampled only in READY
- o_init_done  out  1  high when READY
- i_ren  in  [RD_N]  read enable per port
- i_ra  in  [RD_N][AW]  read address per port
- o_rdata  out  [RD_N][W]  registered read data per port
- o_rvalid  out  [RD_N]  registered valid bit of the addressed word
- i_wen  in  [WR_N]  write enable per port
- i_wa  in  [WR_N][AW]  write address per port
- i_wdata  in  [WR_N][W]  write data per port

## Operation
- FSM with two states, INIT and READY. Async reset enters INIT with sweep counter = 0.
- Reset values: o_init_done=0, o_rdata=0, o_rvalid=0. All N valid bits are cleared asynchronously. Data words are not reset; the sweep zeroes them.
- INIT:
  - Each cycle writes 0 to word[counter] and clears its valid bit, then increments the counter.
  - The last cycle is counter = N-1. On that cycle the FSM moves to READY and the counter returns to 0.
  - i_wen, i_ren and i_init are ignored. o_rdata and o_rvalid are forced to 0.
- READY, write path:
  - Each enabled port writes i_wdata to word[i_wa] and sets that word's valid bit.
  - If several enabled ports target the same address, the highest-index port wins.
  - A write with i_wa >= N is dropped, with no side effects.
- READY, read path:
  - When i_ren[r]=1, o_rdata[r] is registered from word[i_ra[r]] and o_rvalid[r] from its valid bit.
  - When i_ren[r]=0, both outputs hold their previous value.
  - Forwarding is write-first. If an enabled write in the same cycle targets i_ra[r], o_rdata[r] takes the winning write data and o_rvalid[r]=1.
  - A read with i_ra >= N returns o_rdata=0 and o_rvalid=0.
- READY, soft re-init:
  - i_init=1 moves the FSM to INIT on the next edge; o_init_done drops on that edge.
  - Writes presented in that same cycle still complete but are then overwritten by the sweep.
  - Reads in that cycle complete normally.
  - Entering INIT zeroes o_rdata and o_rvalid from the following cycle.
- Reset asserted mid-operation, in either state, returns immediately to the reset values and restarts the full sweep.

## Timing
- Sweep length: o_init_done rises exactly N rising edges after arst_n deasserts (edges counted from the first edge with arst_n high). Soft re-init gives the same N-edge window after the edge that samples i_init.
- Write latency: a write at edge t is visible to a non-forwarded read sampled at edge t+1.
- Read latency: 1 cycle, from the edge that samples i_ren/i_ra to o_rdata/o_rvalid valid.
- There is no combinational path from any input to any output.
- Read and write ports are fully independent. Any number of reads to the same address in one cycle return identical data.

## Test plan
- Reset sweep:
  - Stimulus: N=16; deassert arst_n; hold i_ren=1 on all read ports throughout.
  - Required response: o_init_done=0 for 16 edges, then 1. Every read of address 0..15 returns rdata=0, rvalid=0.
- Write then read:
  - Stimulus: write 0xDEADBEEF to addr 5 via port 0; read addr 5 on the next cycle.
  - Required response: o_rdata=0xDEADBEEF, o_rvalid=1, one cycle after the read.
- Forwarding and collision:
  - Stimulus: in the same cycle, port 0 writes 0x11 to addr 3 and port 1 writes 0x22 to addr 3; read port 0 reads addr 3.
  - Required response: o_rdata=0x22, o_rvalid=1. A later read of addr 3 also returns 0x22.
- Read hold and out-of-range:
  - Stimulus: N=12; read addr 2 (holding 0x7); drop i_ren for 3 cycles; then read addr 14.
  - Required response: o_rdata stays 0x7 while i_ren is low, then o_rdata=0, o_rvalid=0. A write to addr 14 leaves every word unchanged.
- Soft re-init:
  - Stimulus: fill all words; pulse i_init together with a write of 0xAA to addr 1.
  - Required response: o_init_done low for exactly N cycles. Afterwards, reading addr 1 returns 0 with rvalid=0.
- Mid-sweep reset:
  - Stimulus: assert arst_n low at sweep count 7, release it.
  - Required response: outputs are 0 immediately; o_init_done rises N edges after release.
